// File: rtl/alu_pkg.sv
// Shared opcode/state types and opcode classification masks for the sequential ALU.
package alu_pkg;

   localparam int ALU_CTRL_W = 4;

   typedef enum logic [ALU_CTRL_W-1:0] {
      OP_ADD   = 4'b0000,
      OP_SUB   = 4'b0001,
      OP_AND   = 4'b0010,
      OP_OR    = 4'b0011,
      OP_XOR   = 4'b0100,
      OP_SLT   = 4'b0101,
      OP_SLTU  = 4'b0110,
      OP_MUL   = 4'b1000,
      OP_MULHU = 4'b1001,
      OP_DIV   = 4'b1100,
      OP_DIVU  = 4'b1101,
      OP_REM   = 4'b1110,
      OP_REMU  = 4'b1111
   } alu_op_e;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIN
   } alu_state_e;

   // One bit per opcode value, indexed directly by ALUControl.
   localparam logic [15:0] OP_IS_ITER   = 16'hF300;
   localparam logic [15:0] OP_IS_DIV    = 16'hF000;
   localparam logic [15:0] OP_IS_SIGNED = 16'h5000;

endpackage

// File: rtl/alu_iter_core.sv
// Iterative engine: shift-add multiplier and restoring divider on one shared adder.
// Operands for divide are magnitudes; sign correction is done by the caller.
module alu_iter_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  alu_op_e          op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             step_i,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             last_o
);

   localparam int               CNT_W   = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(WIDTH - 1);

   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d;
   logic             div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH:0]   add_x, add_y;
   logic [WIDTH+1:0] add_s;

   // Multiply: hi + m. Divide: {hi, lo msb} - m, top bit set means no borrow.
   assign add_x = div_q ? {hi_q, lo_q[WIDTH-1]} : {1'b0, hi_q};
   assign add_y = div_q ? ~{1'b0, m_q} : (lo_q[0] ? {1'b0, m_q} : '0);
   assign add_s = {1'b0, add_x} + {1'b0, add_y} + {{(WIDTH + 1){1'b0}}, div_q};

   always_comb begin
      hi_d  = hi_q;
      lo_d  = lo_q;
      m_d   = m_q;
      div_d = div_q;
      cnt_d = cnt_q;
      if (load_i) begin
         div_d = OP_IS_DIV[op_i];
         hi_d  = '0;
         lo_d  = OP_IS_DIV[op_i] ? a_i : b_i;
         m_d   = OP_IS_DIV[op_i] ? b_i : a_i;
         cnt_d = CNT_TOP;
      end else if (step_i) begin
         cnt_d = cnt_q - 1'b1;
         if (!div_q) begin
            hi_d = add_s[WIDTH:1];
            lo_d = {add_s[0], lo_q[WIDTH-1:1]};
         end else if (add_s[WIDTH+1]) begin
            hi_d = add_s[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_d = add_x[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi_q  <= '0;
         lo_q  <= '0;
         m_q   <= '0;
         div_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         m_q   <= m_d;
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

   assign hi_o   = hi_q;
   assign lo_o   = lo_q;
   assign last_o = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU with Start/Busy/Done handshake. Simple and illegal ops finish
// at the accepting edge; MUL*/DIV* run WIDTH steps on alu_iter_core then a FIN cycle.
module alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int CTRL_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              Start,
   input  logic [WIDTH-1:0]  SrcA,
   input  logic [WIDTH-1:0]  SrcB,
   input  logic [CTRL_W-1:0] ALUControl,
   output logic              Busy,
   output logic              Done,
   output logic [WIDTH-1:0]  ALUResult,
   output logic              Zero,
   output logic              CarryOut,
   output logic              Overflow,
   output logic              Sign
);

   alu_state_e       state_q, state_d;
   alu_op_e          op_in, op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             zero_q, zero_d, carry_q, carry_d, ovf_q, ovf_d, done_q, done_d;

   logic             sub, add_ovf;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] simple_res;
   logic             simple_c, simple_v;
   logic             is_iter, div_zero, is_signed, sign_a, sign_b;
   logic [WIDTH-1:0] core_a, core_b, core_hi, core_lo, iter_raw, iter_res;
   logic             core_load, core_step, core_last;

   assign op_in = alu_op_e'(ALUControl);

   // SUB, SLT and SLTU all share the A + ~B + 1 path.
   assign sub     = (op_in != OP_ADD);
   assign sum     = {1'b0, SrcA} + {1'b0, sub ? ~SrcB : SrcB} + {{WIDTH{1'b0}}, sub};
   assign add_ovf = (SrcA[WIDTH-1] == (SrcB[WIDTH-1] ^ sub)) && (sum[WIDTH-1] != SrcA[WIDTH-1]);

   always_comb begin
      simple_res = '0;
      simple_c   = 1'b0;
      simple_v   = 1'b0;
      case (op_in)
         OP_ADD, OP_SUB: begin
            simple_res = sum[WIDTH-1:0];
            simple_c   = sum[WIDTH];
            simple_v   = add_ovf;
         end
         OP_AND:           simple_res = SrcA & SrcB;
         OP_OR:            simple_res = SrcA | SrcB;
         OP_XOR:           simple_res = SrcA ^ SrcB;
         OP_SLT:           simple_res[0] = sum[WIDTH-1] ^ add_ovf;
         OP_SLTU:          simple_res[0] = ~sum[WIDTH];
         OP_DIV, OP_DIVU:  simple_res = '1;
         OP_REM, OP_REMU:  simple_res = SrcA;
         default:          simple_res = '0;
      endcase
   end

   assign is_iter   = OP_IS_ITER[ALUControl];
   assign div_zero  = OP_IS_DIV[ALUControl] && (SrcB == '0);
   assign is_signed = OP_IS_SIGNED[ALUControl];
   assign sign_a    = is_signed & SrcA[WIDTH-1];
   assign sign_b    = is_signed & SrcB[WIDTH-1];
   assign core_a    = sign_a ? -SrcA : SrcA;
   assign core_b    = sign_b ? -SrcB : SrcB;

   alu_iter_core #(.WIDTH(WIDTH)) u_core (
      .clk    (clk),
      .rst    (reset),
      .load_i (core_load),
      .op_i   (op_in),
      .a_i    (core_a),
      .b_i    (core_b),
      .step_i (core_step),
      .hi_o   (core_hi),
      .lo_o   (core_lo),
      .last_o (core_last)
   );

   always_comb begin
      case (op_q)
         OP_MULHU, OP_REM, OP_REMU: iter_raw = core_hi;
         default:                   iter_raw = core_lo;
      endcase
   end

   assign iter_res = neg_q ? -iter_raw : iter_raw;

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      neg_d     = neg_q;
      res_d     = res_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      core_load = 1'b0;
      core_step = 1'b0;
      case (state_q)
         IDLE: begin
            if (Start) begin
               op_d = op_in;
               if (is_iter && !div_zero) begin
                  core_load = 1'b1;
                  neg_d     = (op_in == OP_DIV) ? (sign_a ^ sign_b) : sign_a;
                  state_d   = RUN;
               end else begin
                  done_d  = 1'b1;
                  res_d   = simple_res;
                  zero_d  = (simple_res == '0);
                  carry_d = simple_c;
                  ovf_d   = simple_v;
               end
            end
         end
         RUN: begin
            core_step = 1'b1;
            if (core_last) state_d = FIN;
         end
         FIN: begin
            done_d  = 1'b1;
            res_d   = iter_res;
            zero_d  = (iter_res == '0);
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= OP_ADD;
         neg_q   <= 1'b0;
         res_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         res_q   <= res_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         done_q  <= done_d;
      end
   end

   assign Busy      = (state_q != IDLE);
   assign Done      = done_q;
   assign ALUResult = res_q;
   assign Zero      = zero_q;
   assign CarryOut  = carry_q;
   assign Overflow  = ovf_q;
   assign Sign      = res_q[WIDTH-1];

endmodule
